// File: rtl/debug_frame_collector_if.sv
// Controller poll bus plus UART byte channel of the debug frame collector.
// master = collector side, slave = controllers/UART side.
interface debug_frame_collector_if #(
    parameter int NB_CONTROL_FRAME = 32,
    parameter int NB_REQUEST       = 6,
    parameter int NB_BYTE          = 8
);
    logic [NB_REQUEST-1:0]       o_request_select;
    logic [NB_CONTROL_FRAME-1:0] i_frame;
    logic                        i_writing;
    logic [NB_BYTE-1:0]          o_tx_data;
    logic                        o_tx_start;
    logic                        i_tx_done;

    modport master (
        output o_request_select, o_tx_data, o_tx_start,
        input  i_frame, i_writing, i_tx_done
    );

    modport slave (
        input  o_request_select, o_tx_data, o_tx_start,
        output i_frame, i_writing, i_tx_done
    );
endinterface

// File: rtl/debug_frame_collector.sv
// Polls one debug controller, buffers its frames and streams them to a UART LSB byte first.
// Optional feature macro: DEBUG_COLLECTOR_TIMEOUT_EN (abort REQUEST after TIMEOUT silent cycles).
module debug_frame_collector #(
    parameter int                    NB_CONTROL_FRAME = 32,
    parameter int                    NB_REQUEST       = 6,
    parameter int                    NB_BYTE          = 8,
    parameter logic [NB_REQUEST-1:0] IDLE_SELECT      = 6'b1111_11,
    parameter int                    FIFO_DEPTH       = 4,
    parameter int                    TIMEOUT          = 64
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [NB_REQUEST-1:0] i_request_id,
    debug_frame_collector_if.master bus,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow,
    output logic                  o_timeout
);
    localparam int NB_FRAME_BYTES = NB_CONTROL_FRAME / NB_BYTE;
    localparam int AW             = $clog2(FIFO_DEPTH);
    localparam int PW             = AW + 1;
    localparam int BC_W           = $clog2(NB_FRAME_BYTES + 1);

    generate
        if ((NB_CONTROL_FRAME % NB_BYTE) != 0 || TIMEOUT < 1) begin : g_param_check
            $error("debug_frame_collector: bad frame/byte width or TIMEOUT");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE, ST_REQUEST, ST_COLLECT, ST_DRAIN, ST_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [NB_REQUEST-1:0]       id_q, id_d;
    logic [NB_REQUEST-1:0]       select_q, select_d;
    logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [NB_CONTROL_FRAME-1:0] mem_q [FIFO_DEPTH];
    logic [NB_CONTROL_FRAME-1:0] mem_d [FIFO_DEPTH];
    logic [NB_CONTROL_FRAME-1:0] shift_q, shift_d;
    logic [BC_W-1:0]             bytes_left_q, bytes_left_d;
    logic                        ser_active_q, ser_active_d;
    logic                        await_q, await_d;
    logic [NB_BYTE-1:0]          tx_data_q, tx_data_d;
    logic                        tx_start_q, tx_start_d;
    logic                        overflow_q, overflow_d;

    logic start_acc, push_req, push_ok, pop, drop;
    logic fifo_empty, fifo_full, tmo_hit;

    assign start_acc  = (state_q == ST_IDLE) && i_start;
    assign push_req   = ((state_q == ST_REQUEST) || (state_q == ST_COLLECT)) && bus.i_writing;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A frame is only taken when no frame (and hence no byte) is in flight.
    assign pop        = !ser_active_q && !fifo_empty;
    assign push_ok    = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;

`ifdef DEBUG_COLLECTOR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, timeout_d;

    assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        tmo_cnt_d = (state_q == ST_REQUEST) ? tmo_cnt_q + CNT_W'(1) : '0;
        timeout_d = start_acc ? 1'b0
                  : timeout_q | ((state_q == ST_REQUEST) && !bus.i_writing && tmo_hit);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign tmo_hit   = 1'b0;
    assign o_timeout = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge i_clock) begin
        if (i_reset) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (i_start) state_d = ST_REQUEST;
            ST_REQUEST: begin
                if (bus.i_writing) state_d = ST_COLLECT;
                else if (tmo_hit)  state_d = ST_DRAIN;
            end
            ST_COLLECT: if (!bus.i_writing) state_d = ST_DRAIN;
            ST_DRAIN:   if (fifo_empty && !ser_active_q) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs; the select bus is registered from the upcoming state
    always_comb begin
        o_busy   = (state_q != ST_IDLE);
        o_done   = (state_q == ST_DONE);
        select_d = ((state_d == ST_REQUEST) || (state_d == ST_COLLECT)) ? id_d : IDLE_SELECT;
    end

    always_comb begin
        id_d       = start_acc ? i_request_id : id_q;
        overflow_d = start_acc ? 1'b0 : (overflow_q | drop);
        wr_ptr_d   = wr_ptr_q + PW'(push_ok);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        mem_d      = mem_q;
        if (push_ok) mem_d[wr_ptr_q[AW-1:0]] = bus.i_frame;
    end

    // Serializer: load on pop, issue a byte, then wait for its completion.
    always_comb begin
        shift_d      = shift_q;
        bytes_left_d = bytes_left_q;
        ser_active_d = ser_active_q;
        await_d      = await_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        if (await_q) begin
            if (bus.i_tx_done) begin
                await_d = 1'b0;
                if (bytes_left_q == '0) ser_active_d = 1'b0;
            end
        end else if (ser_active_q) begin
            tx_data_d    = shift_q[NB_BYTE-1:0];
            tx_start_d   = 1'b1;
            await_d      = 1'b1;
            shift_d      = shift_q >> NB_BYTE;
            bytes_left_d = bytes_left_q - BC_W'(1);
        end else if (pop) begin
            shift_d      = mem_q[rd_ptr_q[AW-1:0]];
            bytes_left_d = BC_W'(NB_FRAME_BYTES);
            ser_active_d = 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            id_q         <= '0;
            select_q     <= IDLE_SELECT;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            shift_q      <= '0;
            bytes_left_q <= '0;
            ser_active_q <= 1'b0;
            await_q      <= 1'b0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            id_q         <= id_d;
            select_q     <= select_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            shift_q      <= shift_d;
            bytes_left_q <= bytes_left_d;
            ser_active_q <= ser_active_d;
            await_q      <= await_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            overflow_q   <= overflow_d;
        end
    end

    // Frame storage needs no reset: the pointers define what is valid.
    always_ff @(posedge i_clock) begin
        mem_q <= mem_d;
    end

    assign bus.o_request_select = select_q;
    assign bus.o_tx_data        = tx_data_q;
    assign bus.o_tx_start       = tx_start_q;
    assign o_overflow           = overflow_q;
endmodule
